// File: rtl/hermes_inj_arbiter.sv
// Packet-level round-robin arbiter merging N_SRC credit-based Hermes injector
// streams onto one PE peripheral port; a grant is held from header to last payload flit.
module hermes_inj_arbiter #(
    parameter int N_SRC     = 2,
    parameter int FLIT_SIZE = 32,
    parameter int CNT_W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [N_SRC-1:0]           src_rx_i,
    input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
    output logic [N_SRC-1:0]           src_credit_o,
    output logic                       noc_tx_o,
    output logic [FLIT_SIZE-1:0]       noc_data_o,
    input  logic                       noc_credit_i,
    output logic [N_SRC-1:0]           grant_o,
    output logic                       busy_o
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [FLIT_SIZE-1:0] src_flit [N_SRC];
    logic [FLIT_SIZE-1:0] sel_flit;
    logic [IDX_W-1:0]     pick;
    logic                 found;
    logic                 busy;
    logic                 xfer;
    logic                 release_pkt;

    for (genvar s = 0; s < N_SRC; s++) begin : g_unpack
        assign src_flit[s] = src_data_i[s*FLIT_SIZE +: FLIT_SIZE];
    end

    assign busy     = (state_q != IDLE);
    assign sel_flit = src_flit[gidx_q];
    assign xfer     = busy && src_rx_i[gidx_q] && noc_credit_i;

    // First requester at or after rr_q, scanning with wrap-around.
    always_comb begin
        int unsigned c;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            c = 32'(rr_q) + k;
            if (c >= N_SRC) c = c - N_SRC;
            if (!found && src_rx_i[IDX_W'(c)]) begin
                found = 1'b1;
                pick  = IDX_W'(c);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gidx_d      = gidx_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        release_pkt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en_i && found) begin
                    gidx_d  = pick;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (xfer) state_d = SIZE;
            end
            SIZE: begin
                if (xfer) begin
                    cnt_d = sel_flit[CNT_W-1:0];
                    if (sel_flit[CNT_W-1:0] == '0) release_pkt = 1'b1;
                    else                           state_d     = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) release_pkt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_pkt) begin
            state_d = IDLE;
            gidx_d  = '0;
            rr_d    = (gidx_q == IDX_W'(N_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        src_credit_o = '0;
        grant_o      = '0;
        noc_tx_o     = 1'b0;
        noc_data_o   = '0;
        if (busy) begin
            src_credit_o[gidx_q] = noc_credit_i;
            grant_o[gidx_q]      = 1'b1;
            noc_tx_o             = src_rx_i[gidx_q];
            noc_data_o           = sel_flit;
        end
    end

    assign busy_o = busy;

endmodule

// File: tb/tb_hermes_inj_arbiter.sv
// Randomized bench for hermes_inj_arbiter: injector queues drive the DUT and a
// packet-level model (grant owner, flits moved, packet length) predicts every output.
module tb_hermes_inj_arbiter;

    localparam int N_SRC = 2;
    localparam int FW    = 32;
    localparam int CW    = 16;

    logic                  clk = 1'b0;
    logic                  rst_i, en_i, noc_tx_o, noc_credit_i, busy_o;
    logic [N_SRC-1:0]      src_rx_i, src_credit_o, grant_o;
    logic [N_SRC*FW-1:0]   src_data_i;
    logic [FW-1:0]         noc_data_o;

    always #5 clk = ~clk;

    hermes_inj_arbiter #(.N_SRC(N_SRC), .FLIT_SIZE(FW), .CNT_W(CW)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .src_rx_i     (src_rx_i),
        .src_data_i   (src_data_i),
        .src_credit_o (src_credit_o),
        .noc_tx_o     (noc_tx_o),
        .noc_data_o   (noc_data_o),
        .noc_credit_i (noc_credit_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [FW-1:0] srcq [N_SRC][$];

    // Packet-level model: owner (-1 when idle), flits moved, total length (-1 until size seen).
    int m_g = -1, m_pos = 0, m_len = -1, m_rr = 0;

    bit en_r = 1'b1, rst_r = 1'b0, cred_low = 1'b0;
    int cred_pct = 100, gap_pct = 0;
    int gorder[$];
    logic [N_SRC-1:0] prev_grant = '0;
    int busy_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pending();
        int t = 0;
        for (int s = 0; s < N_SRC; s++) t += srcq[s].size();
        return t;
    endfunction

    task automatic add_pkt(input int s, input int sz, input bit junk_hi);
        logic [FW-1:0] szf;
        szf = FW'(sz);
        if (junk_hi) szf[FW-1:CW] = (FW-CW)'($urandom_range(3));
        srcq[s].push_back(32'h0000_0100 | FW'(s));
        srcq[s].push_back(szf);
        for (int i = 0; i < sz; i++) srcq[s].push_back($urandom);
    endtask

    task automatic cycle();
        logic [N_SRC-1:0] rx;
        logic [FW-1:0]    d [N_SRC];
        logic             cr;
        logic [N_SRC-1:0] eg, ec;
        logic             etx;
        logic [FW-1:0]    ed;
        bit               busy, found;
        int               s;
        @(negedge clk);
        for (int i = 0; i < N_SRC; i++) begin
            rx[i] = (srcq[i].size() > 0) && ($urandom_range(99) >= gap_pct);
            d[i]  = (srcq[i].size() > 0) ? srcq[i][0] : $urandom;
            src_data_i[i*FW +: FW] = d[i];
        end
        cr = !cred_low && ($urandom_range(99) < cred_pct);
        src_rx_i = rx; noc_credit_i = cr; en_i = en_r; rst_i = rst_r;
        #1;
        busy = (m_g >= 0);
        eg = '0; ec = '0; etx = 1'b0; ed = '0;
        if (busy) begin
            eg[m_g] = 1'b1; ec[m_g] = cr; etx = rx[m_g]; ed = d[m_g];
        end
        check("busy",   64'(busy_o),       64'(busy));
        check("grant",  64'(grant_o),      64'(eg));
        check("tx",     64'(noc_tx_o),     64'(etx));
        check("data",   64'(noc_data_o),   64'(ed));
        check("credit", 64'(src_credit_o), 64'(ec));
        if (busy_o) busy_cnt++;
        if (grant_o != '0 && prev_grant == '0)
            for (int i = 0; i < N_SRC; i++) if (grant_o[i]) gorder.push_back(i);
        prev_grant = grant_o;

        if (rst_r) begin
            m_g = -1; m_pos = 0; m_len = -1; m_rr = 0;
            for (int i = 0; i < N_SRC; i++) srcq[i].delete();
        end else if (!busy) begin
            if (en_r && rx != '0) begin
                found = 1'b0;
                for (int k = 0; k < N_SRC; k++) begin
                    s = (m_rr + k) % N_SRC;
                    if (!found && rx[s]) begin
                        found = 1'b1; m_g = s; m_pos = 0; m_len = -1;
                    end
                end
            end
        end else if (rx[m_g] && cr) begin
            if (m_pos == 1) m_len = 2 + int'(d[m_g][CW-1:0]);
            void'(srcq[m_g].pop_front());
            m_pos++;
            if (m_len >= 0 && m_pos == m_len) begin
                m_rr = (m_g + 1) % N_SRC;
                m_g  = -1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() > 0 || m_g >= 0) && n < 3000) begin
            cycle();
            n++;
        end
        if (n >= 3000) check("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic reset_pulse();
        rst_r = 1'b1;
        cycle();
        rst_r = 1'b0;
    endtask

    task automatic wait_model(input int target_left);
        int n = 0;
        while (!(m_g >= 0 && m_len >= 0 && (m_len - m_pos) == target_left) && n < 200) begin
            cycle();
            n++;
        end
        if (n >= 200) check("wait_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        logic [FW-1:0] held;
        rst_i = 1'b1; en_i = 1'b0; src_rx_i = '0; src_data_i = '0; noc_credit_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state: nothing pending, all outputs must read zero.
        repeat (3) cycle();

        // Single packet from src0.
        gorder.delete(); busy_cnt = 0;
        srcq[0].push_back(32'h0000_0101); srcq[0].push_back(32'd3);
        srcq[0].push_back(32'h0000_000A); srcq[0].push_back(32'h0000_000B); srcq[0].push_back(32'h0000_000C);
        drain();
        repeat (2) cycle();
        check("single_busy_cycles", 64'(busy_cnt), 64'd5);
        check("single_grant_src", 64'(gorder.size() > 0 ? gorder[0] : -1), 64'd0);

        // rr_ptr moved to 1: simultaneous requests now favour src1.
        gorder.delete();
        add_pkt(0, 1, 1'b0); add_pkt(1, 1, 1'b0);
        drain();
        check("rr_after_single", 64'(gorder.size() > 0 ? gorder[0] : -1), 64'd1);

        // Contention from rr_ptr=0: strict alternation.
        reset_pulse();
        gorder.delete();
        for (int p = 0; p < 3; p++) begin add_pkt(0, 2, 1'b0); add_pkt(1, 2, 1'b0); end
        drain();
        check("contention_count", 64'(gorder.size()), 64'd6);
        for (int i = 0; i < 6 && i < gorder.size(); i++)
            check("contention_order", 64'(gorder[i]), 64'(i % 2));

        // Backpressure mid-payload.
        add_pkt(0, 6, 1'b0);
        wait_model(3);
        cred_low = 1'b1;
        held = srcq[0][0];
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_data_hold", 64'(noc_data_o), 64'(held));
            check("bp_credit_zero", 64'(src_credit_o), 64'd0);
        end
        cred_low = 1'b0;
        drain();

        // Zero-length payload releases right after the size flit.
        reset_pulse();
        gorder.delete();
        add_pkt(0, 0, 1'b0); add_pkt(1, 2, 1'b0);
        drain();
        check("zero_order_len", 64'(gorder.size()), 64'd2);
        check("zero_next_grant", 64'(gorder.size() > 1 ? gorder[1] : -1), 64'd1);

        // en_i gating, then en_i dropped mid-payload.
        en_r = 1'b0;
        add_pkt(1, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("en_gate_grant", 64'(grant_o), 64'd0);
            check("en_gate_tx", 64'(noc_tx_o), 64'd0);
        end
        en_r = 1'b1;
        cycle();
        cycle();
        check("en_grant_next", 64'(grant_o), 64'b10);
        wait_model(2);
        en_r = 1'b0;
        drain();
        en_r = 1'b1;

        // Reset during payload with five payload flits left.
        add_pkt(0, 8, 1'b0);
        wait_model(5);
        reset_pulse();
        cycle();
        check("rst_outputs", 64'({busy_o, noc_tx_o, grant_o, src_credit_o}), 64'd0);
        check("rst_data", 64'(noc_data_o), 64'd0);
        gorder.delete();
        add_pkt(1, 1, 1'b0); add_pkt(0, 1, 1'b0);
        drain();
        check("rst_rr_first", 64'(gorder.size() > 0 ? gorder[0] : -1), 64'd0);

        // Random traffic, gaps, backpressure, en_i toggling, truncated size flits.
        cred_pct = 75; gap_pct = 20;
        for (int c = 0; c < 2500; c++) begin
            en_r = ($urandom_range(9) != 0);
            for (int s = 0; s < N_SRC; s++)
                if (srcq[s].size() < 4 && $urandom_range(3) == 0) add_pkt(s, $urandom_range(5), 1'b1);
            cycle();
        end
        en_r = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
